// File: rtl/rom_bus_if.sv
// rom_bus_if: request/ready memory bus between a master and the boot-ROM slave
interface rom_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  modport master (output req, we, addr, input rdata, ready, err);
  modport slave  (input req, we, addr, output rdata, ready, err);
endinterface

// File: rtl/rom_bus_slave.sv
// rom_bus_slave: bus adapter for boot-ROM port A; ROM_BUS_CACHE_EN adds a one-entry last-word cache
module rom_bus_slave #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  rom_bus_if.slave      bus,
  output logic          ena_o,
  output logic [AW-1:0] addra_o,
  input  logic [31:0]   doa_i
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic          ena_q, ena_d, ready_q, ready_d, err_q, err_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] waddr;
  logic          rd, wr, hit;
  logic [31:0]   cdata;
  logic          unused;
  assign waddr  = bus.addr[AW+1:2];
  assign unused = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign rd     = state_q == S_IDLE && bus.req && !bus.we;
  assign wr     = state_q == S_IDLE && bus.req && bus.we;
`ifdef ROM_BUS_CACHE_EN
  logic [AW-1:0] tag_q;
  logic [31:0]   cdata_q;
  logic          cvalid_q;
  assign hit   = cvalid_q && tag_q == waddr;
  assign cdata = cdata_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      tag_q    <= addra_q;
      cdata_q  <= doa_i;
      cvalid_q <= 1'b1;
    end
  end
`else
  assign hit   = 1'b0;
  assign cdata = '0;
`endif
  always_comb begin
    state_d = state_q == S_IDLE  ? ((wr || (rd && hit)) ? S_RESP : rd ? S_FETCH : S_IDLE) :
              state_q == S_FETCH ? S_WAIT :
              state_q == S_WAIT  ? S_RESP : S_IDLE;
    ena_d   = rd && !hit;
    addra_d = (rd && !hit) ? waddr : addra_q;
    ready_d = wr || (rd && hit) || state_q == S_WAIT;
    err_d   = wr;
    rdata_d = state_q == S_WAIT ? doa_i : (rd && hit) ? cdata : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ena_q   <= 1'b0;
      addra_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign ena_o     = ena_q;
  assign addra_o   = addra_q;
  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
endmodule

// File: doc/rom_bus_slave.md
# rom_bus_slave

Bus-side adapter that fronts read port A of the 512×32 boot ROM and presents it to the CPU/arbiter memory bus as a request/ready slave. Turns a held bus request into a one-cycle ROM enable pulse, absorbs the ROM's one-cycle registered read latency, returns the word with a single-cycle `ready` pulse, and rejects writes with an error response. Sits directly upstream of the ROM's port A. The bus decoder in front of it has already selected the ROM region.

## Interface
Parameters:
- `AW`, 9, ROM word-address width; the ROM depth is 2^AW words.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  1  bus request; held by the master until `ready`.
- `we`  in  1  write strobe qualifying `req`.
- `addr`  in  32  byte address; bits `[AW+1:2]` select the word, all other bits are ignored.
- `rdata`  out  32  read data; valid while `ready`=1, holds its value otherwise.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `ready` for a rejected write.
- `ena`  out  1  ROM port-A enable; registered.
- `addra`  out  AW  ROM port-A word address; registered.
- `doa`  in  32  ROM port-A data, valid the cycle after the ROM samples `ena`=1.

## Operation
- The FSM has four states: IDLE, FETCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - `req`=1 and `we`=0 → FETCH. Latch `addra`<=`addr[AW+1:2]` and set `ena`<=1.
  - `req`=1 and `we`=1 → RESP. Set `ready`<=1 and `err`<=1; `rdata` is unchanged and the ROM is not accessed.
  - `req`=0 → stay in IDLE.
- FETCH: `ena` is high for exactly this cycle, and the ROM samples it at the closing edge. → WAIT, with `ena`<=0.
- WAIT: `doa` is valid. Set `rdata`<=`doa` and `ready`<=1. → RESP.
- RESP: `ready` (and `err` for a write) is high for this one cycle. → IDLE. `req` is ignored during RESP.
- `addra` holds its last value outside FETCH.
- `addr[1:0]` is ignored: misaligned reads return the containing word without error.
- Word-address wrap: any `addr` above the ROM range aliases modulo 2^AW. Example: byte address 0x800 reads word 0 when `AW`=9.

## Timing
- Reset (`rst`=0 at a rising edge), in any state including mid-transaction: state<=IDLE, `ready`=0, `err`=0, `ena`=0, `addra`=0, `rdata`=0, cache invalid. A transaction in flight is dropped with no `ready`.
- Read latency: with `req` sampled at edge N, `ena` is high in cycle N..N+1 and `ready` is high in cycle N+2..N+3. That is three edges from request to `ready`, four cycles per read.
- Write latency: `ready`/`err` are high in the cycle after the sampling edge, two cycles per write.
- Master rule: if `req` is still high during the `ready` cycle, it is treated as a new request at the first edge in IDLE. Back-to-back reads therefore run at one per 4 cycles (uncached).
- `req` deasserted before `ready` (protocol violation): the transaction still completes and `ready` still pulses.
- Only one transaction is outstanding at a time; there is no pipelining.

## Configuration
- Macro `ROM_BUS_CACHE_EN` adds a one-entry last-word cache (tag of AW bits, 32-bit data, valid bit).
- Defined:
  - Every completed ROM read loads the tag with `addra` and the data with `doa`, and sets valid.
  - An IDLE read whose `addr[AW+1:2]` equals the tag while valid goes directly to RESP with `rdata`<=cached data. `ena` stays 0, giving 2-cycle latency.
  - A miss follows the normal path.
  - Writes do not affect the cache.
- Undefined: there is no cache logic, and every read takes the 4-cycle path.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `req`=1 → `ready`, `err`, `ena`, `rdata` all 0 and no ROM access. Release `rst` → first read completes normally.
- **Basic read:** ROM model word k = 0xA5000000|k. Read at `addr`=0x0000004C → `ena` pulses once with `addra`=19. `ready` arrives 3 edges after sampling with `rdata`=0xA5000013 and `err`=0.
- **Write rejection:** `req`=1, `we`=1, `addr`=0x10 → `ready`=`err`=1 the cycle after sampling, `ena` stays 0, and `rdata` keeps the prior value 0xA5000013.
- **Alias/misalign:** `addr`=0x00000803 → `addra`=0, `rdata`=0xA5000000, no error.
- **Back-to-back with mid-transaction reset:**
  - Hold `req` high with `addr` 0x4 then 0x8 → two `ready` pulses 4 cycles apart with data 0xA5000001 and 0xA5000002.
  - Assert `rst` in WAIT → no `ready`, and the state returns to IDLE.
- **Cache (`ROM_BUS_CACHE_EN`):** read 0x20 twice → first takes 4 cycles with one `ena` pulse. Second takes 2 cycles with no `ena` and `rdata`=0xA5000008. Reading 0x24 then misses (4 cycles).
